// File: rtl/sram_like_responder.sv
// sram_like_responder: SRAM-style request/response slave with an internal
// 2^AW x 32 memory, an in-order response queue of DEPTH entries and a
// programmable minimum latency LAT. Define RANDOM_STALL_EN to add LFSR-driven
// pseudo-random stalls on both the accept and the response side.

// One response-queue entry: valid flag, latency countdown and returned data.
module sram_like_responder_slot #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_data,
    output logic        vld,
    output logic        ready,
    output logic [31:0] data
);
    logic [3:0] cnt;

    // Countdown starts at LAT-1 and saturates at zero while the entry waits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld <= 1'b0;
            cnt <= 4'd0;
        end else if (load) begin
            vld <= 1'b1;
            cnt <= 4'(LAT - 1);
        end else if (clear) begin
            vld <= 1'b0;
            cnt <= 4'd0;
        end else if (vld && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Payload is only looked at while vld is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) data <= load_data;
    end

    assign ready = vld && (cnt == 4'd0);
endmodule

module sram_like_responder #(
    parameter int AW    = 10,
    parameter int DEPTH = 2,
    parameter int LAT   = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]             mem [2**AW];
    logic [AW-1:0]           idx;
    logic [31:0]             mem_rd;
    logic [PW-1:0]           head, tail;
    logic [CW-1:0]           count;
    logic [DEPTH-1:0]        slot_ld, slot_clr, slot_vld, slot_rdy;
    logic [DEPTH-1:0][31:0]  slot_data;
    logic [31:0]             rsp_q;
    logic                    accept, retire, stall_acc, stall_rsp;

    // size and the byte-offset / high address bits carry no function here.
    logic unused_bits;
    assign unused_bits = ^{size, addr[1:0], addr[31:AW+2]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef RANDOM_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, steps every cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= 16'hACE1;
        else         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    assign stall_acc = lfsr[0];
    assign stall_rsp = lfsr[1];
`else
    assign stall_acc = 1'b0;
    assign stall_rsp = 1'b0;
`endif

    assign idx     = addr[AW+1:2];
    assign mem_rd  = mem[idx];
    // A retire in this cycle does not open a slot until the next one.
    assign addr_ok = resetn & (count < CW'(DEPTH)) & ~stall_acc;
    assign accept  = req & addr_ok;
    assign data_ok = slot_rdy[head] & ~stall_rsp;
    assign retire  = data_ok;
    assign rdata   = data_ok ? slot_data[head] : rsp_q;

    // Byte-lane writes at the acceptance edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Circular queue pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) tail <= ptr_inc(tail);
            if (retire) head <= ptr_inc(head);
            if (accept && !retire)      count <= count + 1'b1;
            else if (retire && !accept) count <= count - 1'b1;
        end
    end

    // Last returned data, so rdata holds between responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     rsp_q <= 32'h0;
        else if (retire) rsp_q <= slot_data[head];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign slot_ld[i]  = accept && (tail == PW'(i));
        assign slot_clr[i] = retire && (head == PW'(i));
        sram_like_responder_slot #(.LAT(LAT)) u_slot (
            .clk       (clk),
            .resetn    (resetn),
            .load      (slot_ld[i]),
            .clear     (slot_clr[i]),
            .load_data (wr ? 32'h0 : mem_rd),
            .vld       (slot_vld[i]),
            .ready     (slot_rdy[i]),
            .data      (slot_data[i])
        );
    end

    logic unused_vld;
    assign unused_vld = ^slot_vld;
endmodule

// File: doc/sram_like_responder.md
SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 The block SHALL be parameterised as follows, one per line: name, default, meaning.
- AW, 10, word-address bits of the internal memory (2^AW 32-bit words).
- DEPTH, 2, maximum accepted-but-unanswered requests.
- LAT, 1, minimum cycles from acceptance to data_ok (1..15).

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- resetn, in, 1, asynchronous active-low reset.
- req, in, 1, request valid.
- wr, in, 1, 1 = write, 0 = read.
- size, in, 2, access size; informational only, wstrb governs writes.
- addr, in, 32, byte address.
- wstrb, in, 4, byte write enables.
- wdata, in, 32, write data.
- addr_ok, out, 1, request accepted this cycle.
- data_ok, out, 1, one response returned this cycle.
- rdata, out, 32, read data; valid when data_ok is high.

Function
REQ-003 A request SHALL be accepted in the cycle in which req and addr_ok are both 1, at the rising edge of clk.
- addr_ok = (count < DEPTH), plus any stall from REQ-011.
- A response retiring in the same cycle SHALL NOT free a slot for that cycle.

REQ-004 The memory index SHALL be addr[AW+1:2]. addr[1:0] and addr[31:AW+2] SHALL be ignored.

REQ-005 An accepted write SHALL update, at the acceptance edge, each byte lane i of the indexed word for which wstrb[i]=1.

REQ-006 An accepted read SHALL sample the indexed word at the acceptance edge.
- The read SHALL observe every earlier-accepted write.
- The read SHALL NOT observe a write accepted in the same cycle, which is impossible because acceptance is one per cycle.

REQ-007 Every accepted request, read or write, SHALL produce exactly one data_ok pulse.
- Responses SHALL be returned strictly in acceptance order.
- At most one response SHALL be returned per cycle.

REQ-008 Each queue entry SHALL hold a countdown loaded with LAT-1 at acceptance.
- All valid entries' countdowns SHALL decrement each cycle, saturating at 0.
- data_ok SHALL be 1 exactly when the head entry is valid and its countdown is 0.
- The head SHALL retire on that edge.

REQ-009 With LAT=1 and no stalls, data_ok SHALL rise in the cycle following acceptance, giving back-to-back throughput of 1 request per cycle.

REQ-010 rdata SHALL carry the head's read data while data_ok=1.
- For a write response, rdata SHALL be 0.
- rdata SHALL hold its last value when data_ok=0.

Reset
REQ-012 While resetn=0, asynchronously:
- The queue SHALL be emptied and all countdowns cleared.
- addr_ok SHALL be forced 0.
- data_ok SHALL be 0 and rdata SHALL be 32'h0.
- The LFSR SHALL be set to 16'hACE1.

REQ-013 Memory contents SHALL NOT be reset.

REQ-014 Requests in flight when reset asserts SHALL be discarded without a response.

REQ-015 addr_ok SHALL become 1 in the first cycle after resetn deasserts, since the queue is empty.

Configuration
REQ-011 With macro RANDOM_STALL_EN defined, the block SHALL insert pseudo-random stalls from a 16-bit Fibonacci LFSR.
- LFSR polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing every cycle.
- addr_ok SHALL be additionally forced 0 when lfsr[0]=1.
- data_ok SHALL be additionally suppressed when lfsr[1]=1; the head stays until a non-suppressed cycle.
- Ordering and one-response-per-request SHALL be preserved under stalls.
- Without RANDOM_STALL_EN, the LFSR SHALL be absent, there SHALL be no stalls, and timing SHALL be exactly REQ-003 to REQ-009.

Verification
REQ-016 Single read after write, LAT=1, macro off.
- Stimulus: write addr 32'h10, wstrb 4'hF, wdata 32'hDEADBEEF; then read 32'h10.
- Response: write data_ok 1 cycle after acceptance with rdata 0; read data_ok the next cycle with rdata 32'hDEADBEEF.

REQ-017 Byte strobes.
- Stimulus: word 0x20 holds 32'h11223344; write wstrb 4'b0101, wdata 32'hAABBCCDD; read back.
- Response: rdata 32'h11BB33DD.

REQ-018 Full queue, DEPTH=2, LAT=4.
- Stimulus: req held high continuously.
- Response: two acceptances, then addr_ok=0 until the first data_ok; addr_ok returns the cycle after that retire; responses arrive in order.

REQ-019 Aliasing.
- Stimulus: write 32'h00000FFC and 32'h00001FFC with AW=10.
- Response: both hit word 1023; a subsequent read returns the second write's data.

REQ-020 Reset mid-operation.
- Stimulus: deassert resetn with 2 reads outstanding.
- Response: data_ok, rdata and addr_ok go 0 immediately; no stale data_ok after release; first post-reset read returns correct data.

REQ-021 RANDOM_STALL_EN defined, 1000 random reads and writes.
- Response: acceptance count equals data_ok count; scoreboard matches every rdata; at least one addr_ok stall and one data_ok stall observed.
